point_packer_stream: RTL

Streaming, parametrised point packer for the radar point-cloud generator. It receives clean points from the clutter remover and velocities from the Doppler processor on independent valid/ready streams. Velocities are buffered in a small FIFO and each velocity is saturated to the output field width. Each point is paired in order with the oldest buffered velocity, and the packed word is emitted on a registered valid/ready output, together with frame framing, a per-frame point count and an error flag for excess velocities.

---
 rtl/point_packer_stream_if.sv | 36 +++
 rtl/point_packer_stream.sv | 105 ++++++++++
 2 files changed

// File: rtl/point_packer_stream_if.sv
// Handshake bundle for the point packer: point, velocity and packed-output streams.
interface point_packer_stream_if #(
   parameter int POINT_W  = 128,
   parameter int VEL_IN_W = 24,
   parameter int CNT_W    = 16
);
   logic [POINT_W-1:0]  clean_point;
   logic                pt_valid;
   logic                pt_ready;
   logic                pt_last;
   logic [VEL_IN_W-1:0] velocity;
   logic                vel_valid;
   logic                vel_ready;
   logic [POINT_W-1:0]  point_cloud_data;
   logic                out_valid;
   logic                out_ready;
   logic                cloud_last;
   logic [CNT_W-1:0]    cloud_count;
   logic [7:0]          frame_id;
   logic                err_vel_excess;
   logic                err_clr;

   // environment side: produces points/velocities, consumes packed words
   modport master (
      output clean_point, pt_valid, pt_last, velocity, vel_valid, out_ready, err_clr,
      input  pt_ready, vel_ready, point_cloud_data, out_valid, cloud_last,
             cloud_count, frame_id, err_vel_excess
   );

   // packer side
   modport slave (
      input  clean_point, pt_valid, pt_last, velocity, vel_valid, out_ready, err_clr,
      output pt_ready, vel_ready, point_cloud_data, out_valid, cloud_last,
             cloud_count, frame_id, err_vel_excess
   );
endinterface

// File: rtl/point_packer_stream.sv
// Pairs clean points with buffered, saturated Doppler velocities and emits
// packed words with frame framing, per-frame count and an excess-velocity flag.
module point_packer_stream #(
   parameter int POINT_W   = 128,
   parameter int VEL_IN_W  = 24,
   parameter int VEL_W     = 16,
   parameter int VEL_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic rst_n,
   point_packer_stream_if.slave bus
);
   localparam int AW = $clog2(VEL_DEPTH);

   localparam logic [VEL_IN_W-1:0] VMAX = {{(VEL_IN_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
   localparam logic [VEL_IN_W-1:0] VMIN = {{(VEL_IN_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};
   localparam logic [AW:0]         OCC_FULL = (AW+1)'(VEL_DEPTH);
   localparam logic [AW:0]         OCC_TWO  = (AW+1)'(2);
   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

   logic [VEL_W-1:0] mem [VEL_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      occ;
   logic [VEL_W-1:0] vel_sat;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             vel_push, pt_acc;
   logic             unused_low;

   // low point bits are replaced by the velocity field
   assign unused_low = ^bus.clean_point[VEL_W-1:0];

   assign bus.vel_ready = rst_n && (occ != OCC_FULL);
   assign bus.pt_ready  = (occ != '0) && (!bus.out_valid || bus.out_ready);
   assign vel_push      = bus.vel_valid && bus.vel_ready;
   assign pt_acc        = bus.pt_valid && bus.pt_ready;
   assign cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // signed clamp of the incoming velocity to the output field range
   always_comb begin
      vel_sat = bus.velocity[VEL_W-1:0];
      if ($signed(bus.velocity) > $signed(VMAX))
         vel_sat = VMAX[VEL_W-1:0];
      else if ($signed(bus.velocity) < $signed(VMIN))
         vel_sat = VMIN[VEL_W-1:0];
   end

   // velocity storage; contents need no reset since occupancy gates reads
   always_ff @(posedge clk) begin
      if (vel_push)
         mem[wr_ptr] <= vel_sat;
   end

   // FIFO pointers and occupancy; pop reads the pre-push head (no bypass)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (vel_push) wr_ptr <= wr_ptr + 1'b1;
         if (pt_acc)   rd_ptr <= rd_ptr + 1'b1;
         case ({vel_push, pt_acc})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // output register, frame counter and frame id
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.point_cloud_data <= '0;
         bus.out_valid        <= 1'b0;
         bus.cloud_last       <= 1'b0;
         bus.cloud_count      <= '0;
         bus.frame_id         <= '0;
         cnt                  <= '0;
      end else if (pt_acc) begin
         bus.point_cloud_data <= {bus.clean_point[POINT_W-1:VEL_W], mem[rd_ptr]};
         bus.out_valid        <= 1'b1;
         bus.cloud_last       <= bus.pt_last;
         if (bus.pt_last) begin
            bus.cloud_count <= cnt_inc;
            bus.frame_id    <= bus.frame_id + 8'd1;
            cnt             <= '0;
         end else begin
            cnt <= cnt_inc;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // sticky flag: frame closed while more than the popped velocity was queued
   always_ff @(posedge clk) begin
      if (!rst_n)
         bus.err_vel_excess <= 1'b0;
      else if (pt_acc && bus.pt_last && (occ >= OCC_TWO))
         bus.err_vel_excess <= 1'b1;
      else if (bus.err_clr)
         bus.err_vel_excess <= 1'b0;
   end
endmodule
